ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/loader_timeout.sv | 36 +++
 rtl/ram_loader.sv | 131 +++++++++++++
 tb/tb_ram_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared RAM write-port struct, frame SYNC byte and loader FSM states.
// Write port: one registered write per data byte; no backpressure from the RAM side.
package dmem_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic               en;
        logic [DMEM_DW-1:0] in;
    } DMemCtrl;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_e;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter; expired_o flags the edge on which the count would reach TIMEOUT.
// Zero latency, combinational expired_o; clear has priority over enable.
module loader_timeout #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_loader.sv
// Parses SYNC/ADDR/LEN/data/CSUM frames from a byte stream into RAM writes.
// Write lands one cycle after the byte is accepted; rx_ready drops only in RESP and reset.
module ram_loader
    import dmem_pkg::*;
#(
    parameter int D       = 8,
    parameter int A       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [D-1:0] rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output DMemCtrl      dmem_ctrl,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   frames_ok
);

    state_e       state_q, state_d;
    logic [A-1:0] ptr_q, ptr_d;
    logic [D-1:0] len_q, len_d;
    logic [D-1:0] sum_q, sum_d;
    logic         ok_q, ok_d;
    logic [7:0]   frames_q, frames_d;
    logic         rdy_q;
    logic         wr_en_q, wr_en_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [D-1:0] wr_dat_q, wr_dat_d;

    logic xfer;
    logic tmo_clr, tmo_en, tmo_expired;

    assign xfer = rx_valid && rdy_q;

    assign tmo_clr = xfer || (state_q == S_IDLE) || (state_q == S_RESP);
    assign tmo_en  = !xfer && ((state_q == S_ADDR) || (state_q == S_LEN) ||
                               (state_q == S_DATA) || (state_q == S_CSUM));

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        sum_d     = sum_q;
        ok_d      = ok_q;
        frames_d  = frames_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        case (state_q)
            S_IDLE: if (xfer && rx_data == D'(SYNC)) state_d = S_ADDR;
            S_ADDR: if (xfer) begin
                ptr_d   = rx_data[A-1:0];
                sum_d   = rx_data;
                state_d = S_LEN;
            end
            S_LEN: if (xfer) begin
                len_d   = rx_data;
                sum_d   = sum_q + rx_data;
                state_d = (rx_data == '0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (xfer) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_dat_d  = rx_data;
                ptr_d     = ptr_q + 1'b1;
                len_d     = len_q - 1'b1;
                sum_d     = sum_q + rx_data;
                if (len_q == D'(1)) state_d = S_CSUM;
            end
            S_CSUM: if (xfer) begin
                ok_d = (rx_data == sum_q);
                if (rx_data == sum_q) frames_d = frames_q + 8'd1;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Only asserted while no byte transfers, so it never races a CSUM match.
        if (tmo_expired) begin
            state_d = S_RESP;
            ok_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            ok_q      <= 1'b0;
            frames_q  <= '0;
            rdy_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            ok_q      <= ok_d;
            frames_q  <= frames_d;
            rdy_q     <= (state_d != S_RESP);
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    assign rx_ready       = rdy_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_RESP) && ok_q;
    assign err            = (state_q == S_RESP) && !ok_q;
    assign frames_ok      = frames_q;
    assign dmem_ctrl.addr = DMEM_AW'(wr_addr_q);
    assign dmem_ctrl.en   = wr_en_q;
    assign dmem_ctrl.in   = DMEM_DW'(wr_dat_q);

endmodule

// File: tb/tb_ram_loader.sv
// Directed frames against ram_loader with a write logger and pulse counters.
// Checksums are ADDR + LEN + data bytes modulo 256, worked out by hand per frame.
module tb_ram_loader;
    import dmem_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    DMemCtrl    dmem_ctrl;
    logic       busy, done, err;
    logic [7:0] frames_ok;

    int errors = 0;
    int checks = 0;

    logic [15:0] wq[$];
    int          n_done = 0, n_err = 0, n_both = 0;
    logic        rdy_at_done = 1'b1;
    int          lat;

    ram_loader #(.D(8), .A(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .dmem_ctrl (dmem_ctrl),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .frames_ok (frames_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (dmem_ctrl.en) wq.push_back({dmem_ctrl.addr, dmem_ctrl.in});
            if (done) begin
                n_done++;
                rdy_at_done = rx_ready;
            end
            if (err) n_err++;
            if (done && err) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_wait", 32'd0, 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_log();
        wq.delete();
        n_done = 0;
        n_err = 0;
        rdy_at_done = 1'b1;
    endtask

    initial begin
        // Reset state, sampled before any clock edge
        #2;
        chk("rst_ready", rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", dmem_ctrl.en, 0);
        chk("rst_frames", frames_ok, 0);
        chk("rst_done_err", {done, err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", rx_ready, 1);

        // Good frame, back-to-back
        clr_log();
        send(8'hA5); send(8'h10); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h79);
        idle(3);
        chk("good_nwr", wq.size(), 3);
        chk("good_w0", wq[0], 16'h1011);
        chk("good_w1", wq[1], 16'h1122);
        chk("good_w2", wq[2], 16'h1233);
        chk("good_done", n_done, 1);
        chk("good_err", n_err, 0);
        chk("good_frames", frames_ok, 1);
        chk("good_busy", busy, 0);

        // Bad checksum: write still lands
        clr_log();
        send(8'hA5); send(8'h10); send(8'h01); send(8'h55); send(8'h00);
        idle(3);
        chk("bad_nwr", wq.size(), 1);
        chk("bad_w0", wq[0], 16'h1055);
        chk("bad_err", n_err, 1);
        chk("bad_done", n_done, 0);
        chk("bad_frames", frames_ok, 1);

        // Leading noise, pointer wraps FF -> 00
        clr_log();
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'hFE); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03); send(8'h07);
        idle(3);
        chk("wrap_nwr", wq.size(), 3);
        chk("wrap_w0", wq[0], 16'hFE01);
        chk("wrap_w1", wq[1], 16'hFF02);
        chk("wrap_w2", wq[2], 16'h0003);
        chk("wrap_done", n_done, 1);
        chk("wrap_frames", frames_ok, 2);

        // Zero length with idle gaps between bytes
        clr_log();
        send(8'hA5); idle(2);
        send(8'h20); idle(2);
        send(8'h00); idle(2);
        send(8'h20); idle(3);
        chk("zlen_nwr", wq.size(), 0);
        chk("zlen_done", n_done, 1);
        chk("zlen_err", n_err, 0);
        chk("zlen_resp_rdy", rdy_at_done, 0);
        chk("zlen_frames", frames_ok, 3);

        // Timeout after the ADDR byte
        clr_log();
        send(8'hA5); send(8'h10);
        rx_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (err && lat == 0) lat = c;
        end
        chk("tmo_latency", lat, 15);
        chk("tmo_done", n_done, 0);
        chk("tmo_nerr", n_err, 1);
        chk("tmo_idle", busy, 0);
        clr_log();
        send(8'hA5); send(8'h30); send(8'h02); send(8'hAA); send(8'hBB); send(8'h97);
        idle(3);
        chk("tmo_next_nwr", wq.size(), 2);
        chk("tmo_next_w0", wq[0], 16'h30AA);
        chk("tmo_next_w1", wq[1], 16'h31BB);
        chk("tmo_next_done", n_done, 1);
        chk("tmo_next_frames", frames_ok, 4);
        chk("no_done_and_err", n_both, 0);

        // Asynchronous reset in the middle of a 4-byte frame
        clr_log();
        send(8'hA5); send(8'h40); send(8'h04); send(8'h01); send(8'h02);
        chk("mid_pending_en", dmem_ctrl.en, 1);
        chk("mid_pending_wr", {dmem_ctrl.addr, dmem_ctrl.in}, 16'h4102);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_en", dmem_ctrl.en, 0);
        chk("arst_wr", {dmem_ctrl.addr, dmem_ctrl.in}, 16'h0000);
        chk("arst_busy", busy, 0);
        chk("arst_ready", rx_ready, 0);
        chk("arst_frames", frames_ok, 0);
        chk("arst_done_err", {done, err}, 0);
        @(negedge clk);
        @(negedge clk);
        wq.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_ready", rx_ready, 1);
        send(8'h03); send(8'h04);
        idle(3);
        chk("arst_nwr", wq.size(), 0);
        clr_log();
        send(8'hA5); send(8'h50); send(8'h01); send(8'h5A); send(8'hAB);
        idle(3);
        chk("arst_next_nwr", wq.size(), 1);
        chk("arst_next_w0", wq[0], 16'h505A);
        chk("arst_next_done", n_done, 1);
        chk("arst_next_frames", frames_ok, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
